tmds_word_aligner: RTL



---
 rtl/tmds_word_aligner.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/tmds_word_aligner.sv
// Purpose : TMDS word aligner. Finds control-period token runs, pulses bitslip until found, then reports lock.
// Latency : 1 cycle, i_encoded_data -> o_aligned_data, in every state and not gated by lock.
// Backpressure: none; one word per pixel clock, and the downstream decoder must accept every cycle.
//
// Ports
//   i_pixclk        pixel clock; also CLKDIV of the deserializer
//   i_rst_n         asynchronous active-low reset
//   i_encoded_data  deserialized 10-bit TMDS word; bit 9 is the first received bit
//   o_bitslip       one-cycle bitslip request to the deserializer
//   o_aligned_data  registered copy of i_encoded_data
//   o_locked        word alignment achieved
//   o_slip_count    current slip position, 0..9
//   o_loss_count    (only with TMDS_ALIGN_LOSS_CNT_EN) number of lock losses, saturating at 255
//
// Build option: define TMDS_ALIGN_LOSS_CNT_EN to add the o_loss_count port and its counter.
//
// Parameters
//   SEARCH_WINDOW  cycles without a qualifying run before a slip (searching) or before lock
//                  is dropped (locked). Must exceed one video line. Minimum 8.
//   RUN_LEN        consecutive control tokens that qualify a run, 2..255.
//   SETTLE_CYCLES  cycles ignored after each bitslip while the deserializer settles. Minimum 1.

module tmds_word_aligner #(
    parameter int SEARCH_WINDOW = 4096,
    parameter int RUN_LEN       = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       i_pixclk,
    input  logic       i_rst_n,
    input  logic [9:0] i_encoded_data,
    output logic       o_bitslip,
    output logic [9:0] o_aligned_data,
    output logic       o_locked,
`ifdef TMDS_ALIGN_LOSS_CNT_EN
    output logic [3:0] o_slip_count,
    output logic [7:0] o_loss_count
`else
    output logic [3:0] o_slip_count
`endif
);

    localparam int WIN_W = $clog2(SEARCH_WINDOW);
    localparam int RUN_W = $clog2(RUN_LEN + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(RUN_LEN);
    localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(RUN_LEN - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [3:0]       slip_cnt_q, slip_cnt_d;
    logic             bitslip_q, bitslip_d;
    logic             locked_q, locked_d;
    logic [9:0]       data_q;

    logic             tok;
    logic             tok_vld;
    logic             run_hit;
    logic             win_exp;
    logic             settle_done;
    logic             state_chg;
    logic             hunting;

`ifdef TMDS_ALIGN_LOSS_CNT_EN
    logic [7:0]       loss_cnt_q, loss_cnt_d;
`endif

    // ------------------------------------------------------------------
    // Token detect and run/window qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        tok = (i_encoded_data == 10'h354) || (i_encoded_data == 10'h0AB) ||
              (i_encoded_data == 10'h154) || (i_encoded_data == 10'h2AB);

        // Only SEARCH and LOCKED look at the data. SLIP and SETTLE see words that
        // may straddle the old and new boundary, so tokens there mean nothing.
        hunting = (state_q == ST_SEARCH) || (state_q == ST_LOCKED);
        tok_vld = tok && hunting;

        // The current word is the RUN_LEN-th consecutive token. Because run_cnt
        // saturates at RUN_LEN, an unbroken token stream hits exactly once.
        run_hit     = tok_vld && (run_cnt_q == RUN_LAST);
        win_exp     = (win_cnt_q == WIN_LAST);
        settle_done = (settle_cnt_q == SETTLE_LAST);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;

        unique case (state_q)
            ST_SEARCH: begin
                // A run finishing on the last window cycle still wins.
                if (run_hit) begin
                    state_d = ST_LOCKED;
                end else if (win_exp) begin
                    state_d = ST_SLIP;
                end
            end
            ST_SLIP: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_done) begin
                    state_d = ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                // Losing lock goes back to searching at the same slip position;
                // the boundary is likely still right and no slip is issued.
                if (win_exp && !run_hit) begin
                    state_d = ST_SEARCH;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counter and output next-values
    // ------------------------------------------------------------------
    always_comb begin
        state_chg    = (state_d != state_q);

        win_cnt_d    = win_cnt_q;
        run_cnt_d    = run_cnt_q;
        settle_cnt_d = '0;
        slip_cnt_d   = slip_cnt_q;

        // Window: restarts on every state change and on every qualifying run,
        // otherwise counts while the data is being examined.
        if (state_chg || run_hit || !hunting) begin
            win_cnt_d = '0;
        end else begin
            win_cnt_d = win_cnt_q + 1'b1;
        end

        // Run length: broken by any non-token, and forced to zero around a slip.
        if (!tok_vld || (state_d == ST_SLIP) || (state_d == ST_SETTLE)) begin
            run_cnt_d = '0;
        end else if (run_cnt_q != RUN_MAX) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end

        // Settle timer runs only while staying in SETTLE.
        if ((state_q == ST_SETTLE) && (state_d == ST_SETTLE)) begin
            settle_cnt_d = settle_cnt_q + 1'b1;
        end

        // One slip per SLIP cycle; ten positions cover a full 10-bit word.
        if (state_q == ST_SLIP) begin
            slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
        end

        // Outputs are registered decodes of the next state so that the bitslip
        // line into the deserializer is driven straight from a flop.
        bitslip_d = (state_d == ST_SLIP);
        locked_d  = (state_d == ST_LOCKED);
    end

`ifdef TMDS_ALIGN_LOSS_CNT_EN
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if ((state_q == ST_LOCKED) && (state_d == ST_SEARCH) && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_SEARCH;
            win_cnt_q    <= '0;
            run_cnt_q    <= '0;
            settle_cnt_q <= '0;
            slip_cnt_q   <= '0;
            bitslip_q    <= 1'b0;
            locked_q     <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            run_cnt_q    <= run_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            bitslip_q    <= bitslip_d;
            locked_q     <= locked_d;
            data_q       <= i_encoded_data;
        end
    end

`ifdef TMDS_ALIGN_LOSS_CNT_EN
    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign o_loss_count = loss_cnt_q;
`endif

    assign o_bitslip      = bitslip_q;
    assign o_locked       = locked_q;
    assign o_slip_count   = slip_cnt_q;
    assign o_aligned_data = data_q;

endmodule
